rf_wport_arbiter: RTL and testbench

//  Owns the single register-file write port and its hazard scoreboard.
//  - Pipeline WB writes pass straight through with top priority.
//  - Long-latency unit (LLU, mul/div) results are queued in a FIFO and

---
 rtl/rf_wport_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_rf_wport_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: owns the single register-file write port.
// Merges pipeline WB writes with queued long-latency results and
// tracks which registers still wait for such a result.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   wb_we/waddr/wdata  pipeline WB write (top priority)
//   iss_valid/waddr    LLU op issued; marks its destination pending
//   llu_valid/ready    LLU result handshake (ready = FIFO not full)
//   llu_waddr/wdata    LLU result payload
//   id_raddr1/2        ID-stage sources checked against pending
//   id_waddr, id_we    ID-stage destination (WAW check)
//   rf_we/waddr/wdata  register file write port
//   id_stall           hold ID on a pending register hazard
//   starve_stall       request a WB bubble so the FIFO head can drain
//   err                sticky protocol error
module rf_wport_arbiter #(
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        iss_valid,
    input  logic [4:0]  iss_waddr,
    input  logic        llu_valid,
    output logic        llu_ready,
    input  logic [4:0]  llu_waddr,
    input  logic [31:0] llu_wdata,
    input  logic [4:0]  id_raddr1,
    input  logic [4:0]  id_raddr2,
    input  logic [4:0]  id_waddr,
    input  logic        id_we,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        id_stall,
    output logic        starve_stall,
    output logic        err
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STARVE = 2'd2;

    // FIFO storage and pointers (one extra MSB for full/empty)
    logic [4:0]       fifo_addr [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   wr_ptr_nxt;
    logic [PTR_W:0]   rd_ptr_nxt;

    logic             full;
    logic             empty;
    logic             empty_nxt;
    logic [4:0]       head_addr;
    logic [31:0]      head_data;

    logic             wb_free;
    logic             push;
    logic             push_store;
    logic             pop;

    // Scoreboard
    logic [31:0]      pending;
    logic [31:0]      pending_nxt;
    logic [31:0]      set_vec;
    logic [31:0]      clr_vec;
    logic             iss_set;

    // Error detection
    logic             err_q;
    logic             err_iss;
    logic             err_llu;
    logic             err_full;

    // Starvation FSM
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;

    // ------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign head_addr = fifo_addr[rd_ptr[PTR_W-1:0]];
    assign head_data = fifo_data[rd_ptr[PTR_W-1:0]];

    // A WB write to r0 is a no-op, so its slot can carry a queued result.
    assign wb_free = !wb_we || (wb_waddr == 5'd0);

    // Ready never takes credit for a same-cycle pop.
    assign llu_ready  = !rst && !full;
    assign push       = llu_valid && llu_ready;
    // Results for r0 are acknowledged but never stored.
    assign push_store = push && (llu_waddr != 5'd0);
    assign pop        = !rst && wb_free && !empty;

    assign wr_ptr_nxt = wr_ptr + {{PTR_W{1'b0}}, push_store};
    assign rd_ptr_nxt = rd_ptr + {{PTR_W{1'b0}}, pop};
    assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);

    // ------------------------------------------------------------
    // Write port mux
    // ------------------------------------------------------------
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (!wb_free) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (!empty) begin
                rf_we    = 1'b1;
                rf_waddr = head_addr;
                rf_wdata = head_data;
            end
        end
    end

    // ------------------------------------------------------------
    // Scoreboard: set applied after clear so a same-register
    // issue survives the retirement of the previous result.
    // ------------------------------------------------------------
    assign iss_set = iss_valid && (iss_waddr != 5'd0);
    assign set_vec = iss_set ? (32'd1 << iss_waddr) : 32'd0;
    assign clr_vec = pop ? (32'd1 << head_addr) : 32'd0;

    assign pending_nxt = ((pending & ~clr_vec) | set_vec) & ~32'd1;

    assign id_stall = !rst &&
                      (pending[id_raddr1] |
                       pending[id_raddr2] |
                       (id_we & pending[id_waddr]));

    // ------------------------------------------------------------
    // Protocol error sources
    // ------------------------------------------------------------
    assign err_iss  = iss_set && pending[iss_waddr] &&
                      !(pop && (head_addr == iss_waddr));
    assign err_llu  = llu_valid && (llu_waddr != 5'd0) &&
                      !pending[llu_waddr];
    assign err_full = llu_valid && full;

    assign err = err_q;

    // ------------------------------------------------------------
    // Starvation FSM: counts cycles the current head has waited.
    // ------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE: begin
                wait_cnt_nxt = '0;
                if (push_store) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (empty_nxt) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                end else if (pop) begin
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_STARVE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            ST_STARVE: begin
                if (empty_nxt) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                end else if (pop) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    assign starve_stall = !rst && (state == ST_STARVE);

    // ------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pending  <= 32'd0;
            err_q    <= 1'b0;
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            pending  <= pending_nxt;
            err_q    <= err_q | err_iss | err_llu | err_full;
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Payload storage needs no reset; pointers qualify it.
    always_ff @(posedge clk) begin
        if (!rst && push_store) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= llu_waddr;
            fifo_data[wr_ptr[PTR_W-1:0]] <= llu_wdata;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: directed scenarios followed by randomized
// legal traffic, all checked against a queue-based reference model.
module tb_rf_wport_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic        llu_valid;
    logic        llu_ready;
    logic [4:0]  llu_waddr;
    logic [31:0] llu_wdata;
    logic [4:0]  id_raddr1;
    logic [4:0]  id_raddr2;
    logic [4:0]  id_waddr;
    logic        id_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        id_stall;
    logic        starve_stall;
    logic        err;

    rf_wport_arbiter #(
        .DEPTH(DEPTH),
        .PTR_W(2),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb_we(wb_we),
        .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata),
        .iss_valid(iss_valid),
        .iss_waddr(iss_waddr),
        .llu_valid(llu_valid),
        .llu_ready(llu_ready),
        .llu_waddr(llu_waddr),
        .llu_wdata(llu_wdata),
        .id_raddr1(id_raddr1),
        .id_raddr2(id_raddr2),
        .id_waddr(id_waddr),
        .id_we(id_we),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .id_stall(id_stall),
        .starve_stall(starve_stall),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: result queue, pending set, sticky error,
    // and how many cycles the current head has gone unserved.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t       q[$];
    bit         pend_m[32];
    bit         err_m;
    int         age;
    logic [4:0] outstanding[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every output against the model at the falling edge.
    task automatic settle();
        bit          free;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic        e_rdy;
        logic        e_stall;
        logic        e_starve;
        @(negedge clk);
        free     = !wb_we || (wb_waddr == 5'd0);
        e_we     = 1'b0;
        e_a      = 5'd0;
        e_d      = 32'd0;
        e_rdy    = 1'b0;
        e_stall  = 1'b0;
        e_starve = 1'b0;
        if (!rst) begin
            e_rdy = (q.size() < DEPTH);
            if (!free) begin
                e_we = 1'b1;
                e_a  = wb_waddr;
                e_d  = wb_wdata;
            end else if (q.size() > 0) begin
                e_we = 1'b1;
                e_a  = q[0].a;
                e_d  = q[0].d;
            end
            e_stall = pend_m[id_raddr1] || pend_m[id_raddr2] ||
                      (id_we && pend_m[id_waddr]);
            e_starve = (q.size() > 0) && (age >= MAX_WAIT);
        end
        chk("llu_ready", 32'(llu_ready), 32'(e_rdy));
        chk("rf_we", 32'(rf_we), 32'(e_we));
        if (e_we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e_a));
            chk("rf_wdata", rf_wdata, e_d);
        end
        chk("id_stall", 32'(id_stall), 32'(e_stall));
        chk("starve_stall", 32'(starve_stall), 32'(e_starve));
        chk("err", 32'(err), 32'(err_m));
    endtask

    task automatic model_update();
        bit         free;
        bit         popped;
        logic [4:0] pa;
        int         sz;
        if (rst) begin
            q.delete();
            foreach (pend_m[i]) pend_m[i] = 1'b0;
            err_m = 1'b0;
            age   = 0;
        end else begin
            free   = !wb_we || (wb_waddr == 5'd0);
            sz     = q.size();
            popped = free && (sz > 0);
            pa     = popped ? q[0].a : 5'd0;
            if (iss_valid && iss_waddr != 0 && pend_m[iss_waddr] &&
                !(popped && pa == iss_waddr))
                err_m = 1'b1;
            if (llu_valid && llu_waddr != 0 && !pend_m[llu_waddr])
                err_m = 1'b1;
            if (llu_valid && sz == DEPTH)
                err_m = 1'b1;
            if (popped) age = 0;
            else if (sz > 0) begin
                if (age < 1000) age++;
            end else age = 0;
            if (popped) begin
                pend_m[pa] = 1'b0;
                void'(q.pop_front());
            end
            if (llu_valid && sz < DEPTH && llu_waddr != 0)
                q.push_back('{a: llu_waddr, d: llu_wdata});
            if (iss_valid && iss_waddr != 0)
                pend_m[iss_waddr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        rst       = 1'b0;
        wb_we     = 1'b0;
        wb_waddr  = 5'd0;
        wb_wdata  = 32'd0;
        iss_valid = 1'b0;
        iss_waddr = 5'd0;
        llu_valid = 1'b0;
        llu_waddr = 5'd0;
        llu_wdata = 32'd0;
        id_raddr1 = 5'd0;
        id_raddr2 = 5'd0;
        id_waddr  = 5'd0;
        id_we     = 1'b0;
    endtask

    initial begin
        logic [4:0] a;
        int         k;

        foreach (pend_m[i]) pend_m[i] = 1'b0;
        err_m = 1'b0;
        age   = 0;

        // Reset
        idle_inputs();
        rst = 1'b1;
        tick();
        wb_we    = 1'b1;
        wb_waddr = 5'd3;
        settle();
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_ready", 32'(llu_ready), 32'd0);
        tick();
        idle_inputs();
        settle();
        chk("reset_ready", 32'(llu_ready), 32'd1);
        chk("reset_err", 32'(err), 32'd0);
        tick();

        // Scenario 1: issue r5, result 0x1234, WB idle
        iss_valid = 1'b1;
        iss_waddr = 5'd5;
        settle();
        tick();
        iss_valid = 1'b0;
        id_raddr1 = 5'd5;
        llu_valid = 1'b1;
        llu_waddr = 5'd5;
        llu_wdata = 32'h1234;
        settle();
        chk("s1_stall_r5", 32'(id_stall), 32'd1);
        chk("s1_no_bypass", 32'(rf_we), 32'd0);
        tick();
        llu_valid = 1'b0;
        settle();
        chk("s1_rf_we", 32'(rf_we), 32'd1);
        chk("s1_rf_waddr", 32'(rf_waddr), 32'd5);
        chk("s1_rf_wdata", rf_wdata, 32'h1234);
        tick();
        settle();
        chk("s1_stall_drop", 32'(id_stall), 32'd0);
        tick();

        // Scenario 2: WB busy every cycle, one queued entry starves
        idle_inputs();
        wb_we     = 1'b1;
        wb_waddr  = 5'd3;
        iss_valid = 1'b1;
        iss_waddr = 5'd6;
        settle();
        tick();
        iss_valid = 1'b0;
        llu_valid = 1'b1;
        llu_waddr = 5'd6;
        llu_wdata = 32'hcafe_0006;
        settle();
        tick();
        llu_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            wb_wdata = $urandom;
            settle();
            chk("s2_starve", 32'(starve_stall), 32'(i == 9));
            tick();
        end
        wb_we = 1'b0;
        settle();
        chk("s2_pop_we", 32'(rf_we), 32'd1);
        chk("s2_pop_addr", 32'(rf_waddr), 32'd6);
        tick();
        settle();
        chk("s2_idle_starve", 32'(starve_stall), 32'd0);
        chk("s2_idle_we", 32'(rf_we), 32'd0);
        tick();

        // Scenario 3: fill the FIFO behind a busy WB, then overflow
        idle_inputs();
        wb_we    = 1'b1;
        wb_waddr = 5'd3;
        for (int i = 1; i <= 4; i++) begin
            iss_valid = 1'b1;
            iss_waddr = 5'(i);
            settle();
            tick();
        end
        iss_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            llu_valid = 1'b1;
            llu_waddr = 5'(i);
            llu_wdata = 32'h100 + 32'(i);
            settle();
            tick();
        end
        llu_valid = 1'b0;
        settle();
        chk("s3_full_ready", 32'(llu_ready), 32'd0);
        chk("s3_err_before", 32'(err), 32'd0);
        tick();
        llu_valid = 1'b1;
        llu_waddr = 5'd1;
        llu_wdata = 32'hdead;
        settle();
        tick();
        llu_valid = 1'b0;
        settle();
        chk("s3_err_full", 32'(err), 32'd1);
        tick();

        // Free one slot (r1 retires), leaving three entries queued
        wb_we = 1'b0;
        settle();
        chk("s3_pop_addr", 32'(rf_waddr), 32'd1);
        tick();
        wb_we = 1'b1;

        // Scenario 4: hazard lookups
        iss_valid = 1'b1;
        iss_waddr = 5'd7;
        settle();
        tick();
        iss_valid = 1'b0;
        id_raddr2 = 5'd7;
        settle();
        chk("s4_raw_r7", 32'(id_stall), 32'd1);
        tick();
        id_raddr1 = 5'd0;
        id_raddr2 = 5'd0;
        id_waddr  = 5'd0;
        id_we     = 1'b1;
        settle();
        chk("s4_r0_nostall", 32'(id_stall), 32'd0);
        tick();
        iss_valid = 1'b1;
        iss_waddr = 5'd0;
        settle();
        tick();
        iss_valid = 1'b0;
        settle();
        chk("s4_iss_r0", 32'(id_stall), 32'd0);
        tick();
        id_we     = 1'b0;
        id_raddr1 = 5'd5;
        id_raddr2 = 5'd7;
        settle();
        chk("s4_r7_kept", 32'(id_stall), 32'd1);
        tick();

        // Scenario 5: reset with three entries queued
        rst       = 1'b1;
        id_raddr1 = 5'd2;
        settle();
        chk("s5_rst_we", 32'(rf_we), 32'd0);
        chk("s5_rst_stall", 32'(id_stall), 32'd0);
        tick();
        rst   = 1'b0;
        wb_we = 1'b0;
        settle();
        chk("s5_ready", 32'(llu_ready), 32'd1);
        chk("s5_rf_we", 32'(rf_we), 32'd0);
        chk("s5_err", 32'(err), 32'd0);
        chk("s5_pending", 32'(id_stall), 32'd0);
        tick();

        // Scenario 6: r9 retires while r9 is reissued
        idle_inputs();
        iss_valid = 1'b1;
        iss_waddr = 5'd9;
        settle();
        tick();
        iss_valid = 1'b0;
        llu_valid = 1'b1;
        llu_waddr = 5'd9;
        llu_wdata = 32'h9999;
        settle();
        tick();
        llu_valid = 1'b0;
        iss_valid = 1'b1;
        iss_waddr = 5'd9;
        settle();
        chk("s6_pop_r9", 32'(rf_waddr), 32'd9);
        tick();
        iss_valid = 1'b0;
        id_raddr1 = 5'd9;
        settle();
        chk("s6_pend_r9", 32'(id_stall), 32'd1);
        chk("s6_err", 32'(err), 32'd0);
        tick();

        // Clean slate for randomized traffic
        idle_inputs();
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(299, 0) == 0);
            wb_we     = ($urandom_range(3, 0) != 0);
            wb_waddr  = 5'($urandom_range(31, 0));
            wb_wdata  = $urandom;
            id_raddr1 = 5'($urandom_range(31, 0));
            id_raddr2 = 5'($urandom_range(31, 0));
            id_waddr  = 5'($urandom_range(31, 0));
            id_we     = 1'($urandom_range(1, 0));
            iss_valid = 1'b0;
            iss_waddr = 5'($urandom_range(31, 0));
            llu_valid = 1'b0;
            llu_waddr = 5'($urandom_range(31, 0));
            llu_wdata = $urandom;
            if (!rst) begin
                if ($urandom_range(2, 0) == 0) begin
                    a = 5'($urandom_range(31, 1));
                    if (!pend_m[a]) begin
                        iss_valid = 1'b1;
                        iss_waddr = a;
                    end
                end
                if (q.size() < DEPTH) begin
                    if (outstanding.size() > 0 &&
                        $urandom_range(1, 0) == 1) begin
                        k = $urandom_range(outstanding.size() - 1, 0);
                        llu_valid = 1'b1;
                        llu_waddr = outstanding[k];
                        outstanding.delete(k);
                    end else if ($urandom_range(15, 0) == 0) begin
                        llu_valid = 1'b1;
                        llu_waddr = 5'd0;
                    end
                end
                if (iss_valid) outstanding.push_back(iss_waddr);
            end else begin
                outstanding.delete();
            end
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
